// File: rtl/time_string_sender_pkg.sv
// Shared definitions for the time string sender: FSM encoding, ASCII
// constants, frame lengths and a digit-to-ASCII helper.
package time_string_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] FRAME_LEN_BASE = 4'd11;
  localparam logic [3:0] FRAME_LEN_CRLF = 4'd13;

  function automatic logic [7:0] to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'b0000, digit};
  endfunction

endpackage

// File: rtl/time_string_sender_if.sv
// Request/time inputs and TX FIFO write side of the time string sender.
interface time_string_sender_if;
  logic       start;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tx_full;
  logic       push;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;

  modport master (
    output start, msec, sec, min, hour, tx_full,
    input  push, tx_data, busy, done
  );

  modport slave (
    input  start, msec, sec, min, hour, tx_full,
    output push, tx_data, busy, done
  );
endinterface

// File: rtl/time_string_sender_digit.sv
// Binary to two-digit BCD split: ones = v mod 10, tens = (v / 10) mod 10.
module time_digit_split #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] value,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

  assign ones = 4'(value % TEN);
  assign tens = 4'((value / TEN) % TEN);
endmodule

// File: rtl/time_string_sender.sv
// Sends "HH:MM:SS.CC[CR LF]" as ASCII bytes into a TX FIFO, one byte per
// cycle while the FIFO has room, from a snapshot taken at start.
module time_string_sender
  import time_string_sender_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  time_string_sender_if.slave bus
);
  localparam logic [3:0] LAST_IDX = SEND_CRLF ? (FRAME_LEN_CRLF - 4'd1)
                                              : (FRAME_LEN_BASE - 4'd1);

  state_t     state;
  logic [3:0] index;
  logic [4:0] snap_hour;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [6:0] snap_msec;

  logic [3:0] hour_tens, hour_ones, min_tens, min_ones;
  logic [3:0] sec_tens, sec_ones, msec_tens, msec_ones;
  logic [7:0] frame_byte;
  logic       push_int;

  time_digit_split #(.WIDTH(5)) u_hour (.value(snap_hour), .tens(hour_tens), .ones(hour_ones));
  time_digit_split #(.WIDTH(6)) u_min  (.value(snap_min),  .tens(min_tens),  .ones(min_ones));
  time_digit_split #(.WIDTH(6)) u_sec  (.value(snap_sec),  .tens(sec_tens),  .ones(sec_ones));
  time_digit_split #(.WIDTH(7)) u_msec (.value(snap_msec), .tens(msec_tens), .ones(msec_ones));

  // Push is gated combinationally by tx_full so a full FIFO is never written.
  assign push_int    = (state == ST_SEND) && !bus.tx_full;
  assign bus.push    = push_int;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_DONE);
  // Data is forced to zero outside SEND so reset shows 0x00 rather than '0'.
  assign bus.tx_data = (state == ST_SEND) ? frame_byte : 8'h00;

  // Select the frame byte addressed by the current index.
  always_comb begin
    frame_byte = '0;
    case (index)
      4'd0:    frame_byte = to_ascii(hour_tens);
      4'd1:    frame_byte = to_ascii(hour_ones);
      4'd2:    frame_byte = ASCII_COLON;
      4'd3:    frame_byte = to_ascii(min_tens);
      4'd4:    frame_byte = to_ascii(min_ones);
      4'd5:    frame_byte = ASCII_COLON;
      4'd6:    frame_byte = to_ascii(sec_tens);
      4'd7:    frame_byte = to_ascii(sec_ones);
      4'd8:    frame_byte = ASCII_DOT;
      4'd9:    frame_byte = to_ascii(msec_tens);
      4'd10:   frame_byte = to_ascii(msec_ones);
      4'd11:   frame_byte = ASCII_CR;
      4'd12:   frame_byte = ASCII_LF;
      default: frame_byte = '0;
    endcase
  end

  // Frame sequencer: snapshot on start, step the index on each push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
      snap_msec <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            snap_hour <= bus.hour;
            snap_min  <= bus.min;
            snap_sec  <= bus.sec;
            snap_msec <= bus.msec;
            index     <= '0;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (push_int) begin
            if (index == LAST_IDX) begin
              index <= '0;
              state <= ST_DONE;
            end else begin
              index <= index + 4'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_time_string_sender.sv
// Directed bench for time_string_sender: a CR LF instance and a short-frame
// instance share stimulus; expected bytes are hand-computed.
module tb_time_string_sender;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       tx_full;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] msec;
  logic       use_short;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  fr [13];

  time_string_sender_if bus_l ();
  time_string_sender_if bus_s ();

  time_string_sender #(.SEND_CRLF(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  time_string_sender #(.SEND_CRLF(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_l.start   = start & ~use_short;
  assign bus_s.start   = start & use_short;
  assign bus_l.tx_full = tx_full;
  assign bus_s.tx_full = tx_full;
  assign bus_l.hour = hour;
  assign bus_s.hour = hour;
  assign bus_l.min  = min;
  assign bus_s.min  = min;
  assign bus_l.sec  = sec;
  assign bus_s.sec  = sec;
  assign bus_l.msec = msec;
  assign bus_s.msec = msec;

  logic       o_push, o_busy, o_done;
  logic [7:0] o_data;
  assign o_push = use_short ? bus_s.push    : bus_l.push;
  assign o_busy = use_short ? bus_s.busy    : bus_l.busy;
  assign o_done = use_short ? bus_s.done    : bus_l.done;
  assign o_data = use_short ? bus_s.tx_data : bus_l.tx_data;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m,
                          input logic [5:0] s, input logic [6:0] c);
    hour = h; min = m; sec = s; msec = c;
  endtask

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks one frame: n bytes expected from fr[], optional stall window and
  // optional mid-frame start pulse with zeroed inputs; then checks DONE/IDLE.
  task automatic expect_frame(input string name, input int n, input int stall_at,
                              input int stall_len, input int mid_at);
    int idx = 0;
    for (int c = 0; c < n + stall_len; c++) begin
      tx_full = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
      if (c == mid_at) begin
        start = 1'b1;
        set_time('0, '0, '0, '0);
      end else begin
        start = 1'b0;
      end
      #1;
      check($sformatf("%s_busy_c%0d", name, c), 32'(o_busy), 32'd1);
      check($sformatf("%s_done_c%0d", name, c), 32'(o_done), 32'd0);
      if (tx_full) begin
        check($sformatf("%s_stall_push_c%0d", name, c), 32'(o_push), 32'd0);
        check($sformatf("%s_stall_data_c%0d", name, c), 32'(o_data), 32'(fr[idx]));
      end else begin
        check($sformatf("%s_push_b%0d", name, idx), 32'(o_push), 32'd1);
        check($sformatf("%s_data_b%0d", name, idx), 32'(o_data), 32'(fr[idx]));
        idx++;
      end
      tick();
    end
    tx_full = 1'b0;
    start = 1'b0;
    #1;
    check({name, "_done_push"}, 32'(o_push), 32'd0);
    check({name, "_done_pulse"}, 32'(o_done), 32'd1);
    check({name, "_done_busy"}, 32'(o_busy), 32'd1);
    tick();
    check({name, "_idle_done"}, 32'(o_done), 32'd0);
    check({name, "_idle_busy"}, 32'(o_busy), 32'd0);
    check({name, "_idle_push"}, 32'(o_push), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tx_full = 1'b0; use_short = 1'b0;
    set_time('0, '0, '0, '0);
    #1;
    check("rst_push", 32'(o_push), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_short_busy", 32'(bus_s.busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(o_busy), 32'd0);

    // 13:05:09.42 with CR LF, no back-pressure
    set_time(5'd13, 6'd5, 6'd9, 7'd42);
    fr = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h30, 8'h39, 8'h2E,
           8'h34, 8'h32, 8'h0D, 8'h0A};
    send_start();
    expect_frame("basic", 13, 0, 0, -1);

    // Same frame back-to-back, FIFO full for 5 cycles after the 3rd byte
    send_start();
    expect_frame("stall", 13, 3, 5, -1);

    // Inputs zeroed and start re-pulsed mid-frame: snapshot is kept
    send_start();
    expect_frame("midstart", 13, 0, 0, 4);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("midstart_quiet_push_c%0d", c), 32'(o_push), 32'd0);
      check($sformatf("midstart_quiet_busy_c%0d", c), 32'(o_busy), 32'd0);
      tick();
    end

    // Reset after the 6th push aborts the frame immediately
    set_time(5'd13, 6'd5, 6'd9, 7'd42);
    send_start();
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("abort_push_b%0d", c), 32'(o_push), 32'd1);
      check($sformatf("abort_data_b%0d", c), 32'(o_data), 32'(fr[c]));
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("abort_push", 32'(o_push), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_data", 32'(o_data), 32'h00);
    tick();
    rst = 1'b0;
    tick();
    set_time(5'd23, 6'd59, 6'd59, 7'd99);
    fr = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h2E,
           8'h39, 8'h39, 8'h0D, 8'h0A};
    send_start();
    expect_frame("after_rst", 13, 0, 0, -1);

    // Out-of-range values split by the same mod-10 rule
    set_time(5'd31, 6'd0, 6'd0, 7'd127);
    fr = '{8'h33, 8'h31, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E,
           8'h32, 8'h37, 8'h0D, 8'h0A};
    send_start();
    expect_frame("range", 13, 0, 0, -1);

    // Short frame without CR LF on the second instance
    use_short = 1'b1;
    set_time('0, '0, '0, '0);
    fr = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E,
           8'h30, 8'h30, 8'h00, 8'h00};
    #1;
    check("short_idle_busy", 32'(o_busy), 32'd0);
    send_start();
    expect_frame("short", 11, 0, 0, -1);
    check("long_untouched_busy", 32'(bus_l.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_string_sender.md
TIME_STRING_SENDER -- requirements
Module: time_string_sender

Interface
REQ-001 SEND_CRLF, default 1: 1 appends CR LF to each frame (13 bytes); 0 omits them (11 bytes).
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  single-cycle request to send one time frame.
REQ-005 msec  in  7  centiseconds, binary, nominal 0..99.
REQ-006 sec  in  6  seconds, binary, nominal 0..59.
REQ-007 min  in  6  minutes, binary, nominal 0..59.
REQ-008 hour  in  5  hours, binary, nominal 0..23.
REQ-009 tx_full  in  1  downstream TX FIFO full; push is forbidden while high.
REQ-010 push  out  1  write strobe to the TX FIFO; one byte per cycle when high.
REQ-011 tx_data  out  8  ASCII byte; valid whenever push=1.
REQ-012 busy  out  1  high while a frame is in progress (state != IDLE).
REQ-013 done  out  1  one-cycle pulse after the last byte of a frame is pushed.

Function
REQ-014 FSM states: IDLE, SEND, DONE; IDLE->SEND on start=1; SEND->DONE on push of last byte; DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge where start=1 in IDLE, snapshot hour/min/sec/msec into internal registers; frame content comes only from the snapshot.
REQ-016 start while busy=1 is ignored and is not queued.
REQ-017 Frame order: H10 H1 ':' M10 M1 ':' S10 S1 '.' C10 C1 [CR LF].
REQ-018 Digits: d1 = value mod 10, d10 = (value / 10) mod 10, ASCII = 0x30 + digit; out-of-range inputs are split by the same rule (e.g. msec=127 -> "27").
REQ-019 push = (state==SEND) and not tx_full; this is combinational on tx_full, so push drops in the same cycle tx_full rises.
REQ-020 tx_data = frame byte at the current index; the byte index advances only on cycles where push=1.
REQ-021 With tx_full low throughout: start sampled at edge k; pushes in the 13 cycles following edges k..k+12; done=1 in the cycle after edge k+13; the next start is accepted at edge k+15.
REQ-022 While tx_full=1, the index and tx_data hold; no byte is skipped or duplicated.
REQ-023 done is high only in DONE; push is 0 in IDLE and DONE.

Reset
REQ-024 rst forces state=IDLE, index=0, snapshot=0, push=0, done=0, busy=0, tx_data=0x00 immediately, without waiting for a clock edge.
REQ-025 rst mid-frame aborts the frame; bytes already pushed are not recalled, and the next start sends a complete frame from byte 0.

Structure
REQ-026 The shared package holds the FSM state encoding, the ASCII constants (0x30 '0', 0x3A ':', 0x2E '.', 0x0D CR, 0x0A LF) and the frame-length constants 11 and 13.
REQ-027 One sub-module, time_digit_split (binary -> tens/ones BCD, width parameter), is instantiated four times on the snapshot registers.
REQ-028 The byte index is a 4-bit counter; frame byte selection is a case on the index.

Verification
REQ-029 hour=13, min=5, sec=9, msec=42, tx_full=0, start -> 31 33 3A 30 35 3A 30 39 2E 34 32 0D 0A on 13 consecutive push cycles, then done for 1 cycle, then busy=0.
REQ-030 Same frame with tx_full=1 for 5 cycles after the 3rd byte -> push=0 for those 5 cycles with tx_data held at 0x30; resumes with 0x30 0x35...; total exactly 13 pushes.
REQ-031 Change all inputs to 0 and pulse start again during SEND -> frame still carries the snapshot values; exactly one frame is sent.
REQ-032 rst asserted after the 6th push -> push=0 and busy=0 immediately; a later start with 23:59:59.99 -> 32 33 3A 35 39 3A 35 39 2E 39 39 0D 0A.
REQ-033 SEND_CRLF=0, hour=0, min=0, sec=0, msec=0 -> 30 30 3A 30 30 3A 30 30 2E 30 30 (11 pushes), done one cycle after the last push.
REQ-034 msec=127, hour=31 -> C10/C1 = 32 37 and H10/H1 = 33 31; no lockup, done asserted.
